// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall, branch flush, multi-cycle EX hold, EX operand forwarding.
// Latency: strobes and forward selects are combinational from state + inputs; state advances on clk.
// Backpressure: stalls by dropping pc_we/ifid_we; `HAZ_PERF_CNT_EN adds stall/flush counters.
module hazard_ctrl #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_mc_op,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       idex_memread,
  input  logic [4:0] idex_rd,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_regwrite,
  input  logic [4:0] memwb_rd,
  input  logic       memwb_regwrite,
  input  logic       ex_br_taken,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       ex_hold,
  output logic       exmem_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mc_busy
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MC_BUSY  = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] mc_cnt;
  logic             load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] em_rd, input logic em_we,
                                         input logic [4:0] mw_rd, input logic mw_we);
    if (em_we && em_rd != 5'd0 && em_rd == src)      return 2'b10;
    else if (mw_we && mw_rd != 5'd0 && mw_rd == src) return 2'b01;
    else                                             return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(ex_rs, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
  assign fwd_b = fwd_sel(ex_rt, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);

  assign load_use = idex_memread && (idex_rd != 5'd0) &&
                    ((id_uses_rs && id_rs == idex_rd) || (id_uses_rt && id_rt == idex_rd));

  assign mc_busy = (state == MC_BUSY);

  // Gated by rst so outputs take reset values even while inputs signal a hazard.
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    ex_hold      = 1'b0;
    exmem_bubble = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MC_BUSY: begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          ex_hold      = 1'b1;
          exmem_bubble = 1'b1;
        end
        FLUSH:   ifid_flush = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (ex_br_taken)   state <= FLUSH;
          else if (load_use) state <= LD_STALL;
          else if (id_mc_op) begin
            state  <= MC_BUSY;
            mc_cnt <= CNT_W'(MC_LATENCY - 1);
          end
        end
        LD_STALL: state <= RUN;
        MC_BUSY: begin
          if (mc_cnt == CNT_W'(1)) begin
            state  <= RUN;
            mc_cnt <= '0;
          end else begin
            mc_cnt <= mc_cnt - CNT_W'(1);
          end
        end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_we && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (state == RUN && ex_br_taken && flush_count != '1)
        flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
